i2c_write_master: RTL and testbench

Single-master I2C write engine that generates the bus transactions consumed by the I2C peripheral slaves, such as the 7-segment slave at 0x56. Each accepted command produces START, a 7-bit address with W=0, one data byte, and STOP. The engine checks both ACK slots and reports completion and NACK status. It sits between the board control logic (buttons/switches or a host FSM) and the shared SCL/SDA bus.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_qtick_gen.sv | 35 +++
 rtl/i2c_write_master.sv | 203 ++++++++++++++++++++
 tb/tb_i2c_write_master.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write master and its users.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    ADDR     = 3'd2,
    ADDR_ACK = 3'd3,
    DATA     = 3'd4,
    DATA_ACK = 3'd5,
    STOP     = 3'd6
  } i2c_mst_state_t;

  localparam logic       I2C_WRITE      = 1'b0;
  localparam logic [6:0] FND_SLAVE_ADDR = 7'h56;
  localparam int         QTR_MIN        = 4;

  // SCL level inside a 4-quarter bit cell: low for q0/q1, high for q2/q3.
  function automatic logic cell_scl(input logic [1:0] q);
    return q[1];
  endfunction

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-bit tick generator: one-cycle qtick every QTR clocks while enabled.
module i2c_qtick_gen #(
  parameter int QTR = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic reload,
  output logic qtick
);

  localparam int             CW   = $clog2(QTR);
  localparam logic [CW-1:0]  LAST = CW'(QTR - 1);
  localparam logic [CW-1:0]  PRE  = CW'(QTR - 2);

  logic [CW-1:0] cnt_r;
  logic          qtick_r;

  // Divider counter; qtick_r is high while the counter sits on its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= '0;
      qtick_r <= 1'b0;
    end else if (!enable || reload) begin
      cnt_r   <= '0;
      qtick_r <= 1'b0;
    end else begin
      cnt_r   <= (cnt_r == LAST) ? '0 : cnt_r + 1'b1;
      qtick_r <= (cnt_r == PRE);
    end
  end

  assign qtick = qtick_r;

endmodule

// File: rtl/i2c_write_master.sv
// Single-byte I2C write engine: START, address+W, ACK, data, ACK, STOP.
module i2c_write_master
  import i2c_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int I2C_FREQ_HZ = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic       scl,
  inout  wire        sda
);

  localparam int QTR = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ);

  if (QTR < QTR_MIN) begin : g_qtr_check
    $error("i2c_write_master: clock ratio too small, QTR must be at least 4");
  end

  i2c_mst_state_t state_r, state_s;
  logic [1:0] q_r, q_s;
  logic [2:0] bit_r, bit_s;
  logic [7:0] sh_r, sh_s;
  logic [7:0] data_r, data_s;
  logic       scl_r, scl_s;
  logic       sda_oe_r, sda_oe_s;
  logic       busy_r, busy_s;
  logic       done_r, done_s;
  logic       ack_error_r, ack_error_s;
  logic       cmd_ready_r, cmd_ready_s;
  logic       qtick_s;
  logic       reload_s;
  logic       sda_in_s;

  assign sda_in_s = sda;
  assign reload_s = (state_s != state_r);

  i2c_qtick_gen #(.QTR(QTR)) u_qtick (
    .clk    (clk),
    .rst    (rst),
    .enable (busy_r),
    .reload (reload_s),
    .qtick  (qtick_s)
  );

  // Next-state and next-output logic; bus levels are set for the quarter being entered.
  always_comb begin
    state_s     = state_r;
    q_s         = q_r;
    bit_s       = bit_r;
    sh_s        = sh_r;
    data_s      = data_r;
    scl_s       = scl_r;
    sda_oe_s    = sda_oe_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    ack_error_s = ack_error_r;
    cmd_ready_s = cmd_ready_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          state_s     = START;
          q_s         = 2'd0;
          bit_s       = 3'd0;
          sh_s        = {cmd_addr, I2C_WRITE};
          data_s      = cmd_data;
          ack_error_s = 1'b0;
          busy_s      = 1'b1;
          cmd_ready_s = 1'b0;
          scl_s       = 1'b1;
          sda_oe_s    = 1'b1;
        end else begin
          scl_s    = 1'b1;
          sda_oe_s = 1'b0;
        end
      end
      START: begin
        if (qtick_s && (q_r == 2'd0)) begin
          q_s   = 2'd1;
          scl_s = 1'b0;
        end else if (qtick_s) begin
          state_s  = ADDR;
          q_s      = 2'd0;
          bit_s    = 3'd0;
          sda_oe_s = ~sh_r[7];
        end else begin
          q_s = q_r;
        end
      end
      ADDR, DATA: begin
        if (qtick_s) begin
          q_s   = q_r + 2'd1;
          scl_s = cell_scl(q_s);
          if (q_r == 2'd3) begin
            bit_s = bit_r + 3'd1;
            if (bit_r == 3'd7) begin
              state_s  = (state_r == ADDR) ? ADDR_ACK : DATA_ACK;
              sda_oe_s = 1'b0;
            end else begin
              sh_s     = {sh_r[6:0], 1'b0};
              sda_oe_s = ~sh_r[6];
            end
          end else begin
            sda_oe_s = sda_oe_r;
          end
        end else begin
          q_s = q_r;
        end
      end
      ADDR_ACK, DATA_ACK: begin
        if (qtick_s) begin
          q_s   = q_r + 2'd1;
          scl_s = cell_scl(q_s);
          // Last clock of q2 is the ACK sampling point.
          if (q_r == 2'd2) begin
            ack_error_s = ack_error_r | sda_in_s;
          end else if ((q_r == 2'd3) && (state_r == ADDR_ACK) && !ack_error_r) begin
            state_s  = DATA;
            sh_s     = data_r;
            sda_oe_s = ~data_r[7];
          end else if (q_r == 2'd3) begin
            state_s  = STOP;
            sda_oe_s = 1'b1;
          end else begin
            sda_oe_s = 1'b0;
          end
        end else begin
          q_s = q_r;
        end
      end
      STOP: begin
        if (qtick_s && (q_r == 2'd0)) begin
          q_s   = 2'd1;
          scl_s = 1'b1;
        end else if (qtick_s && (q_r == 2'd1)) begin
          q_s      = 2'd2;
          sda_oe_s = 1'b0;
        end else if (qtick_s) begin
          state_s     = IDLE;
          q_s         = 2'd0;
          busy_s      = 1'b0;
          done_s      = 1'b1;
          cmd_ready_s = 1'b1;
        end else begin
          q_s = q_r;
        end
      end
      default: begin
        state_s     = IDLE;
        q_s         = 2'd0;
        bit_s       = 3'd0;
        scl_s       = 1'b1;
        sda_oe_s    = 1'b0;
        busy_s      = 1'b0;
        cmd_ready_s = 1'b1;
      end
    endcase
  end

  // State, shifters and registered bus/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      q_r         <= 2'd0;
      bit_r       <= 3'd0;
      sh_r        <= 8'd0;
      data_r      <= 8'd0;
      scl_r       <= 1'b1;
      sda_oe_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      ack_error_r <= 1'b0;
      cmd_ready_r <= 1'b1;
    end else begin
      state_r     <= state_s;
      q_r         <= q_s;
      bit_r       <= bit_s;
      sh_r        <= sh_s;
      data_r      <= data_s;
      scl_r       <= scl_s;
      sda_oe_r    <= sda_oe_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      ack_error_r <= ack_error_s;
      cmd_ready_r <= cmd_ready_s;
    end
  end

  assign sda       = sda_oe_r ? 1'b0 : 1'bz;
  assign scl       = scl_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign ack_error = ack_error_r;
  assign cmd_ready = cmd_ready_r;

endmodule

// File: tb/tb_i2c_write_master.sv
// Scoreboard bench for i2c_write_master with a behavioural 7-segment slave at 0x56.
module tb_i2c_write_master;

  localparam int CLK_HZ = 100_000_000;
  localparam int I2C_HZ = 1_000_000;
  localparam int QTR    = CLK_HZ / (4 * I2C_HZ);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [6:0] cmd_addr = 7'h00;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, busy, done, ack_error, scl;
  wire        sda;
  logic       slv_oe = 1'b0;

  pullup (sda);
  assign sda = slv_oe ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_write_master #(.CLK_FREQ_HZ(CLK_HZ), .I2C_FREQ_HZ(I2C_HZ)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .busy      (busy),
    .done      (done),
    .ack_error (ack_error),
    .scl       (scl),
    .sda       (sda)
  );

  typedef struct {
    logic       ack_err;
    int         rises;
    int         quarters;
    logic [6:0] seg;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int xfer_cyc = 0;
  int done_cnt = 0;
  int starts = 0;
  int stops = 0;
  int last_rises = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // ---------------- 7-segment slave model ----------------
  localparam logic [2:0] P_IDLE = 3'd0, P_ADDR = 3'd1, P_AACK = 3'd2,
                         P_DATA = 3'd3, P_DACK = 3'd4;
  logic       scl_q = 1'b1, sda_q = 1'b1;
  logic [2:0] s_phase = P_IDLE;
  logic [3:0] s_cnt = 4'd0;
  logic [7:0] s_sh = 8'd0;
  logic [6:0] seg = 7'b1111111;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  always @(posedge clk) begin
    scl_q <= scl;
    sda_q <= sda;
    if (scl && scl_q && sda_q && !sda) begin
      s_phase <= P_ADDR;
      s_cnt   <= 4'd0;
      slv_oe  <= 1'b0;
    end else if (scl && scl_q && !sda_q && sda) begin
      s_phase <= P_IDLE;
      slv_oe  <= 1'b0;
    end else if (scl && !scl_q) begin
      if ((s_phase == P_ADDR || s_phase == P_DATA) && s_cnt < 4'd8) begin
        s_sh  <= {s_sh[6:0], sda};
        s_cnt <= s_cnt + 4'd1;
      end
    end else if (!scl && scl_q) begin
      if (s_phase == P_ADDR && s_cnt == 4'd8) begin
        if (s_sh == 8'hAC) begin
          slv_oe  <= 1'b1;
          s_phase <= P_AACK;
        end else begin
          s_phase <= P_IDLE;
        end
      end else if (s_phase == P_AACK) begin
        slv_oe  <= 1'b0;
        s_phase <= P_DATA;
        s_cnt   <= 4'd0;
      end else if (s_phase == P_DATA && s_cnt == 4'd8) begin
        slv_oe  <= 1'b1;
        seg     <= seg_of(s_sh[3:0]);
        s_phase <= P_DACK;
      end else if (s_phase == P_DACK) begin
        slv_oe  <= 1'b0;
        s_phase <= P_IDLE;
      end
    end
  end

  // ---------------- transfer timestamp ----------------
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready && !rst) xfer_cyc <= cyc;
  end

  // ---------------- bus monitor ----------------
  initial begin
    logic scl_p, sda_p;
    bit in_txn, hi_ok, lo_ok, first_rise;
    int t_rise, t_fall, lo_w, rises;
    scl_p = 1'b1; sda_p = 1'b1;
    in_txn = 0; hi_ok = 0; lo_ok = 0; first_rise = 0;
    t_rise = 0; t_fall = 0; lo_w = 0; rises = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_txn = 0; hi_ok = 0; lo_ok = 0;
      end else if (scl_p && scl && (sda_p != sda)) begin
        if (!sda) begin
          starts++;
          chk("start_outside_txn", int'(in_txn), 0);
          in_txn = 1; rises = 0; hi_ok = 0; lo_ok = 0; first_rise = 1;
        end else begin
          stops++;
          chk("stop_inside_txn", int'(in_txn), 1);
          last_rises = rises;
          in_txn = 0; hi_ok = 0; lo_ok = 0;
        end
      end else if (in_txn && !scl_p && scl) begin
        rises++;
        if (!first_rise) begin
          lo_w = cyc - t_fall;
          lo_ok = 1;
        end
        first_rise = 0;
        t_rise = cyc;
        hi_ok = 1;
      end else if (in_txn && scl_p && !scl) begin
        if (hi_ok) chk("scl_high_width", cyc - t_rise, 2 * QTR);
        if (lo_ok) chk("scl_low_width", lo_w, 2 * QTR);
        hi_ok = 0; lo_ok = 0;
        t_fall = cyc;
      end
      scl_p = scl;
      sda_p = sda;
    end
  end

  // ---------------- done monitor / scoreboard ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        done_cnt++;
        chk("ready_with_done", cmd_ready, 1);
        chk("busy_with_done", busy, 0);
        chk("done_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("ack_error", ack_error, e.ack_err);
          chk("latency", cyc - xfer_cyc - 1, e.quarters * QTR);
          chk("scl_rises", last_rises, e.rises);
          chk("seg", seg, e.seg);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [6:0] a, input logic [7:0] d, input bit push,
                      input logic ae, input int r, input int qs, input logic [6:0] sg);
    int n = 0;
    exp_t e;
    while (!cmd_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1'b1;
    if (push) begin
      e.ack_err = ae; e.rises = r; e.quarters = qs; e.seg = sg;
      exp_q.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("ready_low_after_accept", cmd_ready, 0);
    chk("ack_error_cleared", ack_error, 0);
  endtask

  task automatic wait_dones(input int target);
    int n = 0;
    while (done_cnt < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("done_count", done_cnt, target);
  endtask

  task automatic wait_done_cycle();
    int n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda, 1);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_error", ack_error, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // ACKed write of digit 7
    send(7'h56, 8'h07, 1, 1'b0, 19, 77, 7'b1111000);
    wait_dones(1);

    // address NACK: data phase skipped, digit unchanged
    send(7'h50, 8'h03, 1, 1'b1, 10, 41, 7'b1111000);
    wait_dones(2);

    // back-to-back: second command on the done cycle
    send(7'h56, 8'h0A, 1, 1'b0, 19, 77, 7'b0001000);
    wait_done_cycle();
    send(7'h56, 8'h0F, 1, 1'b0, 19, 77, 7'b0001110);
    wait_dones(4);

    // command pulse while busy is ignored
    send(7'h56, 8'h03, 1, 1'b0, 19, 77, 7'b0110000);
    repeat (300) @(negedge clk);
    chk("ready_while_busy", cmd_ready, 0);
    cmd_addr  = 7'h56;
    cmd_data  = 8'h08;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_dones(5);
    repeat (200) @(negedge clk);
    chk("single_done_after_ignored", done_cnt, 5);

    // reset during DATA bit 3 (q1)
    send(7'h56, 8'h09, 0, 1'b0, 0, 0, 7'b0);
    repeat (51 * QTR + QTR / 2) @(negedge clk);
    chk("scl_low_before_abort", scl, 0);
    rst = 1'b1;
    #1;
    chk("abort_scl", scl, 1);
    chk("abort_sda", sda, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_ack_error", ack_error, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (500) @(negedge clk);
    chk("no_done_after_abort", done_cnt, 5);

    send(7'h56, 8'h05, 1, 1'b0, 19, 77, 7'b0010010);
    wait_dones(6);
    repeat (20) @(negedge clk);

    chk("queue_empty", exp_q.size(), 0);
    chk("start_count", starts, 7);
    chk("stop_count", stops, 6);
    chk("total_dones", done_cnt, 6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
